// File: rtl/alu_issue.sv
`default_nettype none
// ============================================================================
// Module   : alu_issue
// Purpose  : ALU issue stage. Decodes the ALU control code, selects operands
//            and buffers ops in a 2-entry skid FIFO with valid/ready handshakes.
// Options  : ALU_ISSUE_STATS_EN adds issue_count / illegal_count outputs.
// Revision : 1.0 - initial release
// ============================================================================
module alu_issue #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       aluop,
  input  logic [2:0]       funct3,
  input  logic             funct7_5,
  input  logic             use_imm,
  input  logic [WIDTH-1:0] rs1_data,
  input  logic [WIDTH-1:0] rs2_data,
  input  logic [WIDTH-1:0] imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2:0]       control,
  output logic [WIDTH-1:0] in_A,
  output logic [WIDTH-1:0] in_B,
  output logic             illegal
`ifdef ALU_ISSUE_STATS_EN
  ,
  output logic [31:0]      issue_count,
  output logic [31:0]      illegal_count
`endif
);

  localparam logic [2:0] CTRL_ADD = 3'b000;
  localparam logic [2:0] CTRL_SUB = 3'b001;
  localparam logic [2:0] CTRL_AND = 3'b010;
  localparam logic [2:0] CTRL_OR  = 3'b011;
  localparam logic [2:0] CTRL_SHL = 3'b100;
  localparam logic [2:0] CTRL_SHR = 3'b101;

  // Entry layout: {illegal, control[2:0], A, B}
  localparam int ENTRY_W = 2 * WIDTH + 4;

  logic [2:0]         dec_ctrl;
  logic               dec_ill;
  logic [ENTRY_W-1:0] new_entry;
  logic               push;
  logic               pop;

  logic [1:0]         count_q, count_d;
  logic [ENTRY_W-1:0] head_q, head_d;
  logic [ENTRY_W-1:0] tail_q, tail_d;

  always_comb begin
    dec_ctrl = CTRL_ADD;
    dec_ill  = 1'b0;
    case (aluop)
      2'b00: dec_ctrl = CTRL_ADD;
      2'b01: dec_ctrl = CTRL_SUB;
      2'b10: begin
        case (funct3)
          3'b000:  dec_ctrl = (funct7_5 && !use_imm) ? CTRL_SUB : CTRL_ADD;
          3'b111:  dec_ctrl = CTRL_AND;
          3'b110:  dec_ctrl = CTRL_OR;
          3'b001:  dec_ctrl = CTRL_SHL;
          3'b101:  dec_ctrl = CTRL_SHR;
          default: dec_ill  = 1'b1;
        endcase
      end
      default: dec_ill = 1'b1;
    endcase
  end

  assign new_entry = {dec_ill, dec_ctrl, rs1_data, use_imm ? imm : rs2_data};

  // Ready depends only on occupancy (and reset), never on out_ready.
  assign in_ready  = !rst && (count_q != 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_comb begin
    count_d = count_q;
    head_d  = head_q;
    tail_d  = tail_q;
    case (count_q)
      2'd0: begin
        if (push) begin
          head_d  = new_entry;
          count_d = 2'd1;
        end
      end
      2'd1: begin
        if (push && pop) begin
          head_d = new_entry;
        end else if (push) begin
          tail_d  = new_entry;
          count_d = 2'd2;
        end else if (pop) begin
          count_d = 2'd0;
        end
      end
      default: begin
        if (pop) begin
          head_d  = tail_q;
          count_d = 2'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= 2'd0;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      count_q <= count_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

  // Head fields drive the ALU directly; they hold while stalled or empty.
  assign illegal = head_q[ENTRY_W-1];
  assign control = head_q[ENTRY_W-2 -: 3];
  assign in_A    = head_q[2*WIDTH-1 -: WIDTH];
  assign in_B    = head_q[WIDTH-1:0];

`ifdef ALU_ISSUE_STATS_EN
  logic [31:0] issue_cnt_q;
  logic [31:0] illegal_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      issue_cnt_q   <= 32'd0;
      illegal_cnt_q <= 32'd0;
    end else if (pop) begin
      issue_cnt_q <= issue_cnt_q + 32'd1;
      if (illegal) begin
        illegal_cnt_q <= illegal_cnt_q + 32'd1;
      end
    end
  end

  assign issue_count   = issue_cnt_q;
  assign illegal_count = illegal_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_issue.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_issue
// Purpose  : Self-checking bench for alu_issue: queue-based reference model
//            with per-cycle compare plus directed literal checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_issue;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  aluop;
  logic [2:0]  funct3;
  logic        funct7_5;
  logic        use_imm;
  logic [63:0] rs1_data;
  logic [63:0] rs2_data;
  logic [63:0] imm;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  control;
  logic [63:0] in_A;
  logic [63:0] in_B;
  logic        illegal;
`ifdef ALU_ISSUE_STATS_EN
  logic [31:0] issue_count;
  logic [31:0] illegal_count;
`endif

  alu_issue #(.WIDTH(64)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .aluop(aluop), .funct3(funct3), .funct7_5(funct7_5), .use_imm(use_imm),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .control(control), .in_A(in_A), .in_B(in_B), .illegal(illegal)
`ifdef ALU_ISSUE_STATS_EN
    , .issue_count(issue_count), .illegal_count(illegal_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a plain queue of expected ops, at most two deep.
  typedef struct {
    logic [2:0]  ctrl;
    logic        ill;
    logic [63:0] a;
    logic [63:0] b;
  } ent_t;

  ent_t q[$];
  int   m_pops = 0;
  int   m_ills = 0;
  bit   armed  = 0;

  function automatic ent_t expect_op();
    ent_t e;
    e.ctrl = 3'd0;
    e.ill  = 1'b0;
    e.a    = rs1_data;
    e.b    = use_imm ? imm : rs2_data;
    if (aluop == 2'd1) e.ctrl = 3'd1;
    else if (aluop == 2'd3) e.ill = 1'b1;
    else if (aluop == 2'd2) begin
      case (funct3)
        3'd0:    e.ctrl = (funct7_5 && !use_imm) ? 3'd1 : 3'd0;
        3'd7:    e.ctrl = 3'd2;
        3'd6:    e.ctrl = 3'd3;
        3'd1:    e.ctrl = 3'd4;
        3'd5:    e.ctrl = 3'd5;
        default: e.ill  = 1'b1;
      endcase
    end
    return e;
  endfunction

  always @(posedge clk) begin
    bit do_pop;
    bit do_push;
    armed = 1;
    if (rst) begin
      q.delete();
      m_pops = 0;
      m_ills = 0;
    end else begin
      do_pop  = (q.size() > 0) && out_ready;
      do_push = in_valid && (q.size() < 2);
      if (do_pop) begin
        m_pops++;
        if (q[0].ill) m_ills++;
        void'(q.pop_front());
      end
      if (do_push) q.push_back(expect_op());
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      chk("m_in_ready", in_ready, (!rst && q.size() < 2));
      chk("m_out_valid", out_valid, (q.size() > 0));
      if (q.size() > 0) begin
        chk("m_control", control, q[0].ctrl);
        chk("m_illegal", illegal, q[0].ill);
        chk("m_in_A", in_A, q[0].a);
        chk("m_in_B", in_B, q[0].b);
      end
`ifdef ALU_ISSUE_STATS_EN
      chk("m_issue_count", issue_count, m_pops);
      chk("m_illegal_count", illegal_count, m_ills);
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_op(input logic [1:0] op, input logic [2:0] f3, input logic f7,
                        input logic ui, input logic [63:0] r1, input logic [63:0] r2);
    aluop = op; funct3 = f3; funct7_5 = f7; use_imm = ui; rs1_data = r1; rs2_data = r2;
  endtask

  int f3s[4]   = '{6, 1, 5, 7};
  int ctrls[4] = '{3, 4, 5, 2};

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    set_op(2'd0, 3'd0, 1'b0, 1'b0, 64'd0, 64'd0);
    imm = 64'd0;
    tick(); tick();

    // Reset values
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_control", control, 0);
    chk("rst_in_A", in_A, 0);
    chk("rst_in_B", in_B, 0);
    chk("rst_illegal", illegal, 0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", in_ready, 1);

    // Single sub op
    set_op(2'd2, 3'd0, 1'b1, 1'b0, 64'h10, 64'h3);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("sub_valid", out_valid, 1);
    chk("sub_control", control, 3'b001);
    chk("sub_in_A", in_A, 64'h10);
    chk("sub_in_B", in_B, 64'h3);
    tick();
    chk("sub_drained", out_valid, 0);

    // Immediate select turns sub into add
    set_op(2'd2, 3'd0, 1'b1, 1'b1, 64'h20, 64'h5);
    imm = 64'hFFFF_FFFF_FFFF_FFFF;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("imm_control", control, 3'b000);
    chk("imm_in_B", in_B, 64'hFFFF_FFFF_FFFF_FFFF);
    tick();

    // Backpressure: three ops against a stalled consumer
    out_ready = 1'b0;
    set_op(2'd2, 3'd7, 1'b0, 1'b0, 64'd1, 64'd11);
    in_valid = 1'b1;
    tick();
    chk("bp_ready1", in_ready, 1);
    set_op(2'd2, 3'd6, 1'b0, 1'b0, 64'd2, 64'd12);
    tick();
    chk("bp_ready2", in_ready, 0);
    chk("bp_head_ctrl", control, 3'b010);
    set_op(2'd2, 3'd1, 1'b0, 1'b0, 64'd3, 64'd13);
    tick();
    tick();
    chk("bp_hold_ctrl", control, 3'b010);
    chk("bp_hold_A", in_A, 64'd1);
    out_ready = 1'b1;
    tick();
    chk("bp_pop2_ctrl", control, 3'b011);
    chk("bp_pop2_A", in_A, 64'd2);
    tick();
    chk("bp_pop3_ctrl", control, 3'b100);
    chk("bp_pop3_A", in_A, 64'd3);
    in_valid = 1'b0;
    tick();
    chk("bp_drained", out_valid, 0);

    // Full-rate streaming at count 1
    out_ready = 1'b0;
    set_op(2'd2, 3'd7, 1'b0, 1'b0, 64'd100, 64'd0);
    in_valid = 1'b1;
    tick();
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      set_op(2'd2, 3'(f3s[i % 4]), 1'b0, 1'b0, 64'(200 + i), 64'(300 + i));
      tick();
      chk("st_valid", out_valid, 1);
      chk("st_ready", in_ready, 1);
      chk("st_control", control, 64'(ctrls[i % 4]));
      chk("st_in_A", in_A, 64'(200 + i));
    end
    in_valid = 1'b0;
    tick();
    chk("st_drained", out_valid, 0);

    // Illegal encodings
    out_ready = 1'b0;
    set_op(2'd2, 3'd2, 1'b0, 1'b0, 64'd7, 64'd0);
    in_valid = 1'b1;
    tick();
    set_op(2'd3, 3'd0, 1'b0, 1'b0, 64'd8, 64'd0);
    tick();
    in_valid = 1'b0;
    chk("ill1_flag", illegal, 1);
    chk("ill1_control", control, 0);
    chk("ill1_in_A", in_A, 64'd7);
    out_ready = 1'b1;
    tick();
    chk("ill2_flag", illegal, 1);
    chk("ill2_control", control, 0);
    chk("ill2_in_A", in_A, 64'd8);
    tick();
    chk("ill_drained", out_valid, 0);
`ifdef ALU_ISSUE_STATS_EN
    chk("ill_count", illegal_count, 2);
    chk("issue_count_total", issue_count, 16);
`endif

    // Reset with a full buffer
    out_ready = 1'b0;
    set_op(2'd2, 3'd0, 1'b0, 1'b0, 64'd9, 64'd1);
    in_valid = 1'b1;
    tick();
    set_op(2'd2, 3'd0, 1'b0, 1'b0, 64'd10, 64'd1);
    tick();
    chk("full_ready", in_ready, 0);
    rst = 1'b1;
    tick();
    chk("mr_out_valid", out_valid, 0);
    chk("mr_in_A", in_A, 0);
    chk("mr_control", control, 0);
    rst = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("mr_in_ready", in_ready, 1);
    out_ready = 1'b1;
    tick();
    chk("mr_no_stale1", out_valid, 0);
    tick();
    chk("mr_no_stale2", out_valid, 0);
`ifdef ALU_ISSUE_STATS_EN
    chk("mr_issue_count", issue_count, 0);
`endif

    tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
